// File: rtl/lvt_live_value_table.sv
// Live value table: tracks which write port's bank holds the newest value per address.
// Latency: read_sel and write_conflict are registered, 1 cycle after read_addr/we.
// Backpressure: none; every write port can write every cycle, the table never stalls.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high; forces the INIT (table clear) state
//   we             per-write-port enable, NWRITE bits
//   write_addr     packed write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   read_addr      packed read addresses, port r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   read_sel       registered bank index per read port, port r at [r*SEL_WIDTH +: SEL_WIDTH]
//   init_busy      1 while the table is being cleared after reset
//   write_conflict registered one-cycle pulse: two or more enabled ports hit one address
module lvt_live_value_table #(
  parameter int NWRITE     = 2,
  parameter int NREAD      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int SEL_WIDTH  = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NWRITE-1:0]               we,
  input  logic [NWRITE*ADDR_WIDTH-1:0]    write_addr,
  input  logic [NREAD*ADDR_WIDTH-1:0]     read_addr,
  output logic [NREAD*SEL_WIDTH-1:0]      read_sel,
  output logic                            init_busy,
  output logic                            write_conflict
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  init_cnt;
  logic [SEL_WIDTH-1:0]   entry [DEPTH];
  logic                   conflict_d;

  // Any pair of enabled write ports targeting the same address this cycle.
  always_comb begin
    conflict_d = 1'b0;
    for (int p = 0; p < NWRITE; p++) begin
      for (int q = p + 1; q < NWRITE; q++) begin
        if (we[p] && we[q] &&
            (write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == write_addr[q*ADDR_WIDTH +: ADDR_WIDTH])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Table updates on the falling edge, the same edge the data banks write.
  // That places the update half a cycle ahead of the rising-edge lookup, so a
  // read issued in the same cycle as a write already sees the new owner.
  // Ports are visited in ascending order, so on a shared address the
  // highest-index port's assignment is the one that sticks.
  always_ff @(negedge clock) begin
    if (state == ST_INIT) begin
      entry[init_cnt] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p]) begin
          entry[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= SEL_WIDTH'(p);
        end
      end
    end
  end

  // Control FSM with registered outputs. INIT walks the counter over every
  // address (cleared on the falling edges) and leaves at the edge that sees the
  // last address, giving exactly DEPTH busy cycles after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_INIT;
      init_cnt       <= '0;
      init_busy      <= 1'b1;
      read_sel       <= '0;
      write_conflict <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          read_sel       <= '0;
          write_conflict <= 1'b0;
          if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
            init_cnt  <= '0;
          end else begin
            init_cnt  <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          for (int r = 0; r < NREAD; r++) begin
            read_sel[r*SEL_WIDTH +: SEL_WIDTH] <= entry[read_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
          end
          write_conflict <= conflict_d;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
